// File: rtl/hex_display_mmio.sv
// hex_display_mmio: memory-mapped 4-digit decimal display.
// A store to ADDR latches a value, converts it to BCD one bit per clock
// (shift-add-3) and drives four active-low 7-segment digits.
module hex_display_mmio #(
  parameter logic [15:0] ADDR   = 16'hFFFE,
  parameter int          DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [15:0]       waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              blank,
  output logic [6:0]        hex3,
  output logic [6:0]        hex2,
  output logic [6:0]        hex1,
  output logic [6:0]        hex0,
  output logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              ovf
);

  // Five BCD digits cover any value up to 16 bits (max 65535).
  localparam int BCD_W = 20;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_next;
  logic [3:0]        dig3, dig2, dig1, dig0;
  logic              accept;

  // Nibble correction applied before each shift so the digit stays decimal.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Active-low segment code, bit0 = a .. bit6 = g.
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign accept = en && (waddr == ADDR);
  assign busy   = (state != IDLE);

  // One shift-add-3 step: correct every BCD nibble, then shift the whole register.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < BCD_W / 4; i++) begin
      sr_adj[DATA_W + 4*i +: 4] = add3(sr[DATA_W + 4*i +: 4]);
    end
    sr_next = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Next-state logic; a matching store restarts conversion from any state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      CONVERT: if (cnt == CNT_LAST) next_state = LOAD;
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (accept) next_state = CONVERT;
  end

  // State register, conversion datapath and displayed digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      value <= '0;
      dig3  <= '0;
      dig2  <= '0;
      dig1  <= '0;
      dig0  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        value <= wdata;
        sr    <= {{BCD_W{1'b0}}, wdata};
        cnt   <= '0;
      end else if (state == CONVERT) begin
        sr  <= sr_next;
        cnt <= cnt + 1'b1;
      end else if (state == LOAD) begin
        dig3 <= sr[DATA_W+12 +: 4];
        dig2 <= sr[DATA_W+8  +: 4];
        dig1 <= sr[DATA_W+4  +: 4];
        dig0 <= sr[DATA_W    +: 4];
        ovf  <= (sr[SR_W-1 -: 4] != 4'd0);
      end
    end
  end

  assign hex3 = blank ? 7'h7F : seg(dig3);
  assign hex2 = blank ? 7'h7F : seg(dig2);
  assign hex1 = blank ? 7'h7F : seg(dig1);
  assign hex0 = blank ? 7'h7F : seg(dig0);

endmodule

// File: tb/tb_hex_display_mmio.sv
// Directed bench for hex_display_mmio: reset, conversions, ignored
// addresses, restart on back-to-back stores, mid-conversion reset, blanking.
module tb_hex_display_mmio;

  localparam logic [15:0] ADDR = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst, en, blank;
  logic [15:0] waddr, wdata;
  logic [6:0]  hex3, hex2, hex1, hex0;
  logic [15:0] value;
  logic        busy, ovf;

  int total = 0;
  int bad   = 0;

  hex_display_mmio #(.ADDR(ADDR), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .waddr(waddr), .wdata(wdata),
    .blank(blank), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .value(value), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, "_hex3"}, {9'd0, hex3}, {9'd0, e3});
    chk({tag, "_hex2"}, {9'd0, hex2}, {9'd0, e2});
    chk({tag, "_hex1"}, {9'd0, hex1}, {9'd0, e1});
    chk({tag, "_hex0"}, {9'd0, hex0}, {9'd0, e0});
  endtask

  // Drive one store cycle; returns at the falling edge after the accept edge.
  task automatic store(input logic [15:0] a, input logic [15:0] d);
    en = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; waddr = 16'h0000; wdata = 16'h0000;
  endtask

  // Busy must hold for 17 sampled cycles after the accept, display unchanged
  // until the update edge, then busy drops.
  task automatic wait_conv(input string tag, input logic [6:0] old0);
    for (int i = 0; i < 17; i++) begin
      chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
      @(negedge clk);
      if (i == 15) chk({tag, "_hold"}, {9'd0, hex0}, {9'd0, old0});
    end
    chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; blank = 1'b0; waddr = 16'h0000; wdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk_hex("rst", 7'h40, 7'h40, 7'h40, 7'h40);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    chk("rst_value", value, 16'd0);

    // 1234
    store(ADDR, 16'd1234);
    chk("v1234_value", value, 16'd1234);
    wait_conv("c1234", 7'h40);
    chk_hex("d1234", 7'h79, 7'h24, 7'h30, 7'h19);
    chk("d1234_ovf", {15'd0, ovf}, 16'd0);

    // 12345 overflows: low digits 2345
    @(negedge clk);
    store(ADDR, 16'd12345);
    wait_conv("c12345", 7'h19);
    chk_hex("d12345", 7'h24, 7'h30, 7'h19, 7'h12);
    chk("d12345_ovf", {15'd0, ovf}, 16'd1);

    // 65535: low digits 5535
    store(ADDR, 16'd65535);
    wait_conv("c65535", 7'h12);
    chk_hex("d65535", 7'h12, 7'h12, 7'h30, 7'h12);
    chk("d65535_ovf", {15'd0, ovf}, 16'd1);
    chk("d65535_value", value, 16'd65535);

    // Store to a neighbouring address is ignored
    store(ADDR - 16'd1, 16'd777);
    for (int i = 0; i < 40; i++) begin
      chk("other_busy", {15'd0, busy}, 16'd0);
      @(negedge clk);
    end
    chk("other_value", value, 16'd65535);
    chk_hex("other", 7'h12, 7'h12, 7'h30, 7'h12);
    chk("other_ovf", {15'd0, ovf}, 16'd1);

    // 42 then 9 seven cycles later: only 9 is ever displayed
    store(ADDR, 16'd42);
    for (int i = 0; i < 6; i++) begin
      chk("restart_busy", {15'd0, busy}, 16'd1);
      @(negedge clk);
    end
    store(ADDR, 16'd9);
    chk("restart_value", value, 16'd9);
    for (int i = 0; i < 17; i++) begin
      chk("restart_busy2", {15'd0, busy}, 16'd1);
      chk("no_0042", {15'd0, (hex1 == 7'h19 && hex0 == 7'h24)}, 16'd0);
      @(negedge clk);
    end
    chk("restart_idle", {15'd0, busy}, 16'd0);
    chk_hex("d9", 7'h40, 7'h40, 7'h40, 7'h10);
    chk("d9_ovf", {15'd0, ovf}, 16'd0);

    // Reset at cnt=8 aborts the conversion
    store(ADDR, 16'd4321);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("mid_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk_hex("abort", 7'h40, 7'h40, 7'h40, 7'h40);
    chk("abort_value", value, 16'd0);
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk_hex("abort_late", 7'h40, 7'h40, 7'h40, 7'h40);
    blank = 1'b1;
    #1;
    chk_hex("blank0", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    blank = 1'b0;
    #1;
    chk_hex("unblank0", 7'h40, 7'h40, 7'h40, 7'h40);

    // Blank over a nonzero display; unblank restores in the same cycle
    @(negedge clk);
    store(ADDR, 16'd1234);
    wait_conv("c1234b", 7'h40);
    blank = 1'b1;
    #1;
    chk_hex("blank1", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    blank = 1'b0;
    #1;
    chk_hex("unblank1", 7'h79, 7'h24, 7'h30, 7'h19);

    // Reset wins over a store on the same edge
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1; waddr = ADDR; wdata = 16'd5678;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    chk("prio_value", value, 16'd0);
    chk("prio_busy", {15'd0, busy}, 16'd0);
    chk_hex("prio", 7'h40, 7'h40, 7'h40, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
